// File: rtl/hist2d_bin_coord.sv
// Converts one signed I/Q sample pair into 2D histogram bin coordinates using
// a per-axis offset and bin width, with sequential restoring division.
module hist2d_bin_coord #(
  parameter int SAMPLE_W = 16,
  parameter int COORD_W  = 8
) (
  input  logic                clk100,
  input  logic                reset_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [SAMPLE_W-1:0] q_sample,
  input  logic [SAMPLE_W-1:0] i_min,
  input  logic [SAMPLE_W-1:0] q_min,
  input  logic [SAMPLE_W-1:0] i_bin_width,
  input  logic [SAMPLE_W-1:0] q_bin_width,
  input  logic [COORD_W-1:0]  i_bin_num,
  input  logic [COORD_W-1:0]  q_bin_num,
  output logic                busy,
  output logic                data_out,
  output logic [COORD_W-1:0]  i_bin_coord,
  output logic [COORD_W-1:0]  q_bin_coord,
  output logic                out_of_range,
  output logic [15:0]         drop_count
);

  localparam int DW    = SAMPLE_W + 1;
  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] OFFSET = 2'd1;
  localparam logic [1:0] DIV    = 2'd2;
  localparam logic [1:0] OUT    = 2'd3;

  // One restoring step: the quotient register starts out holding the dividend
  // and shifts it out MSB first while quotient bits shift in at the bottom.
  function automatic logic [SAMPLE_W+DW-1:0] div_step(
    input logic [SAMPLE_W-1:0] rem,
    input logic [DW-1:0]       quo,
    input logic [SAMPLE_W-1:0] dvs
  );
    logic [SAMPLE_W:0]   partial;
    logic [SAMPLE_W-1:0] diff;
    partial = {rem, quo[DW-1]};
    diff    = partial[SAMPLE_W-1:0] - dvs;
    if (partial >= {1'b0, dvs})
      return {diff, quo[DW-2:0], 1'b1};
    else
      return {partial[SAMPLE_W-1:0], quo[DW-2:0], 1'b0};
  endfunction

  // Returns {flag, coord}; checks are ordered so config errors win over range.
  function automatic logic [COORD_W:0] axis_result(
    input logic                neg,
    input logic [DW-1:0]       quo,
    input logic [SAMPLE_W-1:0] wid,
    input logic [COORD_W-1:0]  num
  );
    if (wid == '0 || num == '0)
      return {1'b1, {COORD_W{1'b0}}};
    else if (neg)
      return {1'b1, {COORD_W{1'b0}}};
    else if (quo >= DW'(num))
      return {1'b1, num - 1'b1};
    else
      return {1'b0, quo[COORD_W-1:0]};
  endfunction

  logic [1:0]          state_q, state_d;
  logic [SAMPLE_W-1:0] i_smp_q, i_smp_d, q_smp_q, q_smp_d;
  logic [SAMPLE_W-1:0] i_min_q, i_min_d, q_min_q, q_min_d;
  logic [SAMPLE_W-1:0] i_wid_q, i_wid_d, q_wid_q, q_wid_d;
  logic [COORD_W-1:0]  i_num_q, i_num_d, q_num_q, q_num_d;
  logic                i_neg_q, i_neg_d, q_neg_q, q_neg_d;
  logic [DW-1:0]       i_quo_q, i_quo_d, q_quo_q, q_quo_d;
  logic [SAMPLE_W-1:0] i_rem_q, i_rem_d, q_rem_q, q_rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                data_out_q, data_out_d;
  logic [COORD_W-1:0]  i_coord_q, i_coord_d, q_coord_q, q_coord_d;
  logic                oor_q, oor_d;
  logic [15:0]         drop_q, drop_d;

  logic [DW-1:0]          i_off, q_off;
  logic [SAMPLE_W+DW-1:0] i_step, q_step;
  logic [COORD_W:0]       i_res, q_res;

  // Sign-extend both operands so the difference is exact at DW bits.
  always_comb begin
    i_off  = {i_smp_q[SAMPLE_W-1], i_smp_q} - {i_min_q[SAMPLE_W-1], i_min_q};
    q_off  = {q_smp_q[SAMPLE_W-1], q_smp_q} - {q_min_q[SAMPLE_W-1], q_min_q};
    i_step = div_step(i_rem_q, i_quo_q, i_wid_q);
    q_step = div_step(q_rem_q, q_quo_q, q_wid_q);
    i_res  = axis_result(i_neg_q, i_quo_q, i_wid_q, i_num_q);
    q_res  = axis_result(q_neg_q, q_quo_q, q_wid_q, q_num_q);
  end

  always_comb begin
    state_d    = state_q;
    i_smp_d    = i_smp_q;
    q_smp_d    = q_smp_q;
    i_min_d    = i_min_q;
    q_min_d    = q_min_q;
    i_wid_d    = i_wid_q;
    q_wid_d    = q_wid_q;
    i_num_d    = i_num_q;
    q_num_d    = q_num_q;
    i_neg_d    = i_neg_q;
    q_neg_d    = q_neg_q;
    i_quo_d    = i_quo_q;
    q_quo_d    = q_quo_q;
    i_rem_d    = i_rem_q;
    q_rem_d    = q_rem_q;
    cnt_d      = cnt_q;
    data_out_d = 1'b0;
    i_coord_d  = i_coord_q;
    q_coord_d  = q_coord_q;
    oor_d      = oor_q;
    drop_d     = drop_q;

    if (sample_valid && state_q != IDLE && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          i_smp_d = i_sample;
          q_smp_d = q_sample;
          i_min_d = i_min;
          q_min_d = q_min;
          i_wid_d = i_bin_width;
          q_wid_d = q_bin_width;
          i_num_d = i_bin_num;
          q_num_d = q_bin_num;
          state_d = OFFSET;
        end
      end
      OFFSET: begin
        i_neg_d = i_off[DW-1];
        q_neg_d = q_off[DW-1];
        i_quo_d = i_off;
        q_quo_d = q_off;
        i_rem_d = '0;
        q_rem_d = '0;
        cnt_d   = CNT_W'(SAMPLE_W);
        state_d = DIV;
      end
      DIV: begin
        {i_rem_d, i_quo_d} = i_step;
        {q_rem_d, q_quo_d} = q_step;
        if (cnt_q == '0)
          state_d = OUT;
        else
          cnt_d = cnt_q - 1'b1;
      end
      OUT: begin
        data_out_d = 1'b1;
        i_coord_d  = i_res[COORD_W-1:0];
        q_coord_d  = q_res[COORD_W-1:0];
        oor_d      = i_res[COORD_W] | q_res[COORD_W];
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      i_smp_q    <= '0;
      q_smp_q    <= '0;
      i_min_q    <= '0;
      q_min_q    <= '0;
      i_wid_q    <= '0;
      q_wid_q    <= '0;
      i_num_q    <= '0;
      q_num_q    <= '0;
      i_neg_q    <= 1'b0;
      q_neg_q    <= 1'b0;
      i_quo_q    <= '0;
      q_quo_q    <= '0;
      i_rem_q    <= '0;
      q_rem_q    <= '0;
      cnt_q      <= '0;
      data_out_q <= 1'b0;
      i_coord_q  <= '0;
      q_coord_q  <= '0;
      oor_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      i_smp_q    <= i_smp_d;
      q_smp_q    <= q_smp_d;
      i_min_q    <= i_min_d;
      q_min_q    <= q_min_d;
      i_wid_q    <= i_wid_d;
      q_wid_q    <= q_wid_d;
      i_num_q    <= i_num_d;
      q_num_q    <= q_num_d;
      i_neg_q    <= i_neg_d;
      q_neg_q    <= q_neg_d;
      i_quo_q    <= i_quo_d;
      q_quo_q    <= q_quo_d;
      i_rem_q    <= i_rem_d;
      q_rem_q    <= q_rem_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      i_coord_q  <= i_coord_d;
      q_coord_q  <= q_coord_d;
      oor_q      <= oor_d;
      drop_q     <= drop_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign data_out     = data_out_q;
  assign i_bin_coord  = i_coord_q;
  assign q_bin_coord  = q_coord_q;
  assign out_of_range = oor_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_hist2d_bin_coord.sv
// Directed self-checking bench for hist2d_bin_coord: latency, per-axis
// binning rules, drop counting and asynchronous reset mid-conversion.
module tb_hist2d_bin_coord;

  localparam int SAMPLE_W = 16;
  localparam int COORD_W  = 8;

  logic                clk100;
  logic                reset_n;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] i_sample, q_sample;
  logic [SAMPLE_W-1:0] i_min, q_min;
  logic [SAMPLE_W-1:0] i_bin_width, q_bin_width;
  logic [COORD_W-1:0]  i_bin_num, q_bin_num;
  logic                busy;
  logic                data_out;
  logic [COORD_W-1:0]  i_bin_coord, q_bin_coord;
  logic                out_of_range;
  logic [15:0]         drop_count;

  int checks = 0;
  int errors = 0;

  hist2d_bin_coord #(.SAMPLE_W(SAMPLE_W), .COORD_W(COORD_W)) dut (
    .clk100       (clk100),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .i_sample     (i_sample),
    .q_sample     (q_sample),
    .i_min        (i_min),
    .q_min        (q_min),
    .i_bin_width  (i_bin_width),
    .q_bin_width  (q_bin_width),
    .i_bin_num    (i_bin_num),
    .q_bin_num    (q_bin_num),
    .busy         (busy),
    .data_out     (data_out),
    .i_bin_coord  (i_bin_coord),
    .q_bin_coord  (q_bin_coord),
    .out_of_range (out_of_range),
    .drop_count   (drop_count)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Strobe one sample for exactly one rising edge, driven from the falling edge.
  task automatic applyStimulus(input int i_val, input int q_val);
    @(negedge clk100);
    sample_valid = 1'b1;
    i_sample     = 16'(i_val);
    q_sample     = 16'(q_val);
    @(negedge clk100);
    sample_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(posedge clk100);
      #1;
      n++;
    end while (!data_out && n < 40);
    checkOutput({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic checkResult(input string tag, input int exp_i, input int exp_q, input int exp_oor);
    checkOutput({tag, "_i_coord"}, int'(i_bin_coord), exp_i);
    checkOutput({tag, "_q_coord"}, int'(q_bin_coord), exp_q);
    checkOutput({tag, "_oor"}, int'(out_of_range), exp_oor);
    checkOutput({tag, "_busy_low"}, int'(busy), 0);
  endtask

  task automatic runSample(input string tag, input int i_val, input int q_val,
                           input int exp_i, input int exp_q, input int exp_oor);
    applyStimulus(i_val, q_val);
    waitResult(tag, 19);
    checkResult(tag, exp_i, exp_q, exp_oor);
    @(posedge clk100);
    #1;
    checkOutput({tag, "_strobe_clear"}, int'(data_out), 0);
  endtask

  task automatic baseConfig();
    i_min       = 16'(-1000);
    i_bin_width = 16'd100;
    i_bin_num   = 8'd20;
    q_min       = 16'd0;
    q_bin_width = 16'd8;
    q_bin_num   = 8'd32;
  endtask

  initial begin
    int seen;
    reset_n      = 1'b1;
    sample_valid = 1'b0;
    i_sample     = '0;
    q_sample     = '0;
    baseConfig();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk100);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_data_out", int'(data_out), 0);
    checkOutput("reset_i_coord", int'(i_bin_coord), 0);
    checkOutput("reset_q_coord", int'(q_bin_coord), 0);
    checkOutput("reset_oor", int'(out_of_range), 0);
    checkOutput("reset_drop", int'(drop_count), 0);
    reset_n = 1'b1;

    $display("[TB] nominal conversion");
    runSample("nominal", 250, 100, 12, 12, 0);

    $display("[TB] config change after capture");
    applyStimulus(250, 100);
    i_bin_width = 16'd7;
    q_bin_num   = 8'd1;
    waitResult("cfg_change", 19);
    checkResult("cfg_change", 12, 12, 0);
    baseConfig();

    $display("[TB] per-axis range clamping");
    runSample("i_below", -1500, 0, 0, 0, 1);
    runSample("i_above", 5000, 0, 19, 0, 1);
    runSample("q_above", 250, 300, 12, 31, 1);

    $display("[TB] extremes");
    i_min       = 16'h8000;
    i_bin_width = 16'd1;
    i_bin_num   = 8'd255;
    runSample("i_max", 32767, 0, 254, 0, 1);
    runSample("i_at_min", -32768, 0, 0, 0, 0);

    $display("[TB] zero bin width");
    baseConfig();
    i_bin_width = 16'd0;
    runSample("i_width0", 250, 100, 0, 12, 1);
    baseConfig();

    $display("[TB] strobes while busy");
    applyStimulus(250, 100);
    repeat (4) @(negedge clk100);
    applyStimulus(-1500, 0);
    repeat (4) @(negedge clk100);
    applyStimulus(5000, 0);
    waitResult("drop", 7);
    checkResult("drop", 12, 12, 0);
    checkOutput("drop_count_2", int'(drop_count), 2);
    applyStimulus(5000, 0);
    checkOutput("accept_at_20_busy", int'(busy), 1);
    waitResult("accept_at_20", 19);
    checkResult("accept_at_20", 19, 0, 1);
    checkOutput("drop_count_held", int'(drop_count), 2);

    $display("[TB] reset mid-conversion");
    applyStimulus(250, 100);
    repeat (8) @(posedge clk100);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_data_out", int'(data_out), 0);
    checkOutput("midrst_i_coord", int'(i_bin_coord), 0);
    checkOutput("midrst_q_coord", int'(q_bin_coord), 0);
    checkOutput("midrst_oor", int'(out_of_range), 0);
    checkOutput("midrst_drop", int'(drop_count), 0);
    repeat (2) @(negedge clk100);
    reset_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk100);
      #1;
      if (data_out) seen = 1;
    end
    checkOutput("midrst_no_strobe", seen, 0);
    runSample("after_reset", 250, 100, 12, 12, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
